// File: rtl/pixel_clk_gen.sv
// DDS pixel-clock synthesizer: a phase accumulator clocked by inclk0 produces a
// square-wave c0, a rising-edge strobe c0_en and a lock indicator.
module pixel_clk_gen #(
    parameter int                   ACC_WIDTH   = 32,
    parameter logic [ACC_WIDTH-1:0] FTW_DEFAULT = {1'b1, {(ACC_WIDTH-1){1'b0}}},
    parameter int                   LOCK_CYCLES = 16
) (
    input  logic                 inclk0,
    input  logic                 reset,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_load,
    output logic                 c0,
    output logic                 c0_en,
    output logic                 locked,
    output logic [ACC_WIDTH-1:0] ftw_active
);

    localparam logic [ACC_WIDTH-1:0] NYQUIST  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [15:0]          LOCK_MAX = 16'(LOCK_CYCLES);

    // Tuning words above half the accumulator range would alias, so cap them there.
    function automatic logic [ACC_WIDTH-1:0] clamp_ftw(input logic [ACC_WIDTH-1:0] f);
        return (f > NYQUIST) ? NYQUIST : f;
    endfunction

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] next_acc;
    logic [15:0]          lock_cnt;
    logic [15:0]          lock_cnt_next;

    always_comb begin
        next_acc      = acc + ftw_active;
        lock_cnt_next = lock_cnt;
        if (ftw_load || (ftw_active == '0)) begin
            lock_cnt_next = '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt_next = lock_cnt + 16'd1;
        end
    end

    // The load edge still advances by the old word, keeping the phase continuous.
    always_ff @(posedge inclk0) begin
        if (reset) begin
            acc        <= '0;
            ftw_active <= clamp_ftw(FTW_DEFAULT);
            c0         <= 1'b0;
            c0_en      <= 1'b0;
            locked     <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            acc      <= next_acc;
            c0       <= next_acc[ACC_WIDTH-1];
            c0_en    <= ~acc[ACC_WIDTH-1] & next_acc[ACC_WIDTH-1];
            lock_cnt <= lock_cnt_next;
            locked   <= (lock_cnt_next == LOCK_MAX) && (ftw_active != '0);
            if (ftw_load) begin
                ftw_active <= clamp_ftw(ftw_in);
            end
        end
    end

endmodule

// File: tb/tb_pixel_clk_gen.sv
// Directed self-checking bench for pixel_clk_gen; expected values are hand-derived
// from the accumulator arithmetic.
module tb_pixel_clk_gen;

    logic        inclk0;
    logic        reset;
    logic [31:0] ftw_in;
    logic        ftw_load;
    logic        c0;
    logic        c0_en;
    logic        locked;
    logic [31:0] ftw_active;

    int errors = 0;
    int checks = 0;

    pixel_clk_gen #(
        .ACC_WIDTH  (32),
        .FTW_DEFAULT(32'h8000_0000),
        .LOCK_CYCLES(16)
    ) dut (
        .inclk0    (inclk0),
        .reset     (reset),
        .ftw_in    (ftw_in),
        .ftw_load  (ftw_load),
        .c0        (c0),
        .c0_en     (c0_en),
        .locked    (locked),
        .ftw_active(ftw_active)
    );

    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    // Inputs change 1ns after a rising edge, so outputs are sampled away from it.
    task automatic applyStimulus(input logic rst, input logic load, input logic [31:0] ftw);
        reset    = rst;
        ftw_load = load;
        ftw_in   = ftw;
        @(posedge inclk0);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkPins(input string tag, input logic e_c0, input logic e_en, input logic e_lock);
        checkOutput({tag, ".c0"}, {31'd0, c0}, {31'd0, e_c0});
        checkOutput({tag, ".c0_en"}, {31'd0, c0_en}, {31'd0, e_en});
        checkOutput({tag, ".locked"}, {31'd0, locked}, {31'd0, e_lock});
    endtask

    initial begin
        int unsigned u;
        int          pulses;
        logic        prev_en;
        logic        back_to_back;

        reset    = 1'b1;
        ftw_load = 1'b0;
        ftw_in   = '0;
        #1;

        // Reset state and default word
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkPins("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.ftw_active", ftw_active, 32'h8000_0000);

        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkPins($sformatf("default.e%0d", k), (k % 2) == 1, (k % 2) == 1, k >= 16);
        end

        // Quarter rate: load edge adds the old half-rate word, landing on 2/4
        applyStimulus(1'b0, 1'b1, 32'h4000_0000);
        checkOutput("quarter.ftw_active", ftw_active, 32'h4000_0000);
        checkPins("quarter.j0", 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            u = (2 + j) % 4;
            checkPins($sformatf("quarter.j%0d", j), u >= 2, u == 2, j >= 16);
        end

        // Eighth rate: load edge adds the quarter word, landing on 6/8
        applyStimulus(1'b0, 1'b1, 32'h2000_0000);
        checkOutput("eighth.ftw_active", ftw_active, 32'h2000_0000);
        checkPins("eighth.j0", 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            u = (6 + j) % 8;
            checkPins($sformatf("eighth.j%0d", j), u >= 4, u == 4, j >= 16);
        end

        // Clamp: acc goes 0x4000_0000 -> 0x6000_0000, then alternates with 0xE000_0000
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("clamp.ftw_active", ftw_active, 32'h8000_0000);
        checkPins("clamp.j0", 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkPins($sformatf("clamp.j%0d", j), (j % 2) == 1, (j % 2) == 1, j >= 16);
        end

        // Zero word loaded as acc steps to 0xE000_0000, so c0 freezes high
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("zero.ftw_active", ftw_active, 32'h0);
        checkPins("zero.j0", 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkPins($sformatf("zero.j%0d", j), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 32'h4000_0000);
        checkPins("resume.e0", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkPins("resume.e1", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkPins("resume.e2", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkPins("resume.e3", 1'b1, 1'b1, 1'b0);

        // Reset beats a simultaneous load
        applyStimulus(1'b1, 1'b1, 32'h1234_5678);
        checkOutput("prio.ftw_active", ftw_active, 32'h8000_0000);
        checkPins("prio", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkPins($sformatf("prio.e%0d", k), (k % 2) == 1, (k % 2) == 1, k >= 16);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkPins("midlock_reset", 1'b0, 1'b0, 1'b0);

        // Fractional word ~inclk0/3
        applyStimulus(1'b0, 1'b1, 32'h5555_5555);
        checkOutput("fract.ftw_active", ftw_active, 32'h5555_5555);
        checkPins("fract.j0", 1'b1, 1'b1, 1'b0);
        pulses       = 0;
        prev_en      = c0_en;
        back_to_back = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (c0_en) pulses++;
            if (c0_en && prev_en) back_to_back = 1'b1;
            prev_en = c0_en;
        end
        $display("[TB] fractional pulses counted: %0d", pulses);
        checkOutput("fract.count_in_range", {31'd0, (pulses >= 999) && (pulses <= 1001)}, 32'd1);
        checkOutput("fract.back_to_back", {31'd0, back_to_back}, 32'd0);
        checkOutput("fract.locked", {31'd0, locked}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_clk_gen.md
Name: pixel_clk_gen

Overview:
Digital pixel-clock synthesizer driven by the 50 MHz board clock. It uses a phase accumulator (DDS) to generate a square-wave pixel clock c0, a one-cycle pixel strobe, and a lock indicator. The VGA timing generator runs from c0, or from inclk0 gated by c0_en. The block needs no vendor primitives, and the frequency is runtime-tunable through a frequency tuning word (FTW).

Parameters:
- ACC_WIDTH, 32, phase accumulator and FTW width in bits.
- FTW_DEFAULT, 32'h8000_0000, FTW loaded at reset (inclk0/2).
- LOCK_CYCLES, 16, consecutive stable cycles required before locked asserts; range 1..65535.

Ports:
- inclk0  input  1  reference clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ftw_in  input  ACC_WIDTH  new frequency tuning word.
- ftw_load  input  1  single-cycle load strobe for ftw_in.
- c0  output  1  synthesized pixel clock, registered.
- c0_en  output  1  one-cycle pulse marking each c0 rising edge.
- locked  output  1  high once the output frequency is stable.
- ftw_active  output  ACC_WIDTH  FTW currently in use.

Behaviour:
- Reset, sampled on the rising edge of inclk0, sets: acc=0, ftw_active=FTW_DEFAULT (clamped, see below), c0=0, c0_en=0, locked=0, lock counter=0.
- Reset has priority over ftw_load when both are high in the same cycle.
- Accumulator, every cycle while not in reset:
  - next_acc = (acc + ftw_active) mod 2^ACC_WIDTH; acc <= next_acc.
  - c0 <= next_acc[MSB].
  - c0_en <= ~acc[MSB] & next_acc[MSB].
  - c0 and c0_en are therefore registered together, and c0_en is high only in the first cycle of each c0 high phase.
- Output frequency f_c0 = f_inclk0 × ftw_active / 2^ACC_WIDTH.
- Load:
  - When ftw_load=1, ftw_active <= clamp(ftw_in) at that edge.
  - The accumulator keeps running and is not cleared, so phase stays continuous.
  - The cycle of the load still adds the old ftw_active; the new value applies from the next cycle.
- Clamp: any FTW greater than 2^(ACC_WIDTH-1) becomes 2^(ACC_WIDTH-1), the Nyquist limit. FTW=0 is accepted unchanged.
- FTW=0: acc freezes, c0 holds its current level, c0_en=0, and locked stays 0.
- Lock counter:
  - Clears to 0 on reset, on any ftw_load, and whenever ftw_active==0.
  - Otherwise increments each cycle and saturates at LOCK_CYCLES.
  - locked is registered: locked <= (counter reaches LOCK_CYCLES) & (ftw_active != 0).
  - locked deasserts at the edge following a load.
- A load carrying the same FTW value still drops locked and restarts the count.
- Accumulator wraps silently with no overflow flag.
- Asserting reset mid-period forces c0 low on the next edge, regardless of phase.

Test Plan:
1. Default FTW: release reset. First edge gives acc=0x8000_0000, c0=1, c0_en=1; second edge gives c0=0, c0_en=0. c0 then toggles every cycle with c0_en on alternate cycles. locked=1 on the 16th edge after reset release and stays high.
2. Load ftw_in=0x4000_0000. c0 period is 4 inclk0 cycles with 2 high and 2 low, and c0_en is one pulse per 4 cycles. locked drops the next edge and reasserts 16 cycles later. Repeat with 0x2000_0000 for a period of 8.
3. Clamp: load 0xFFFF_FFFF. ftw_active reads 0x8000_0000 and c0 toggles every cycle.
4. Zero FTW: load 0 while c0=1. c0 stays 1 indefinitely, c0_en=0 and locked=0. Loading 0x4000_0000 afterwards resumes from the frozen phase.
5. Priority and reset: assert reset and ftw_load together. Result is ftw_active=FTW_DEFAULT, acc=0, c0=0, locked=0. Asserting reset mid-lock drops locked on the next edge.
6. Fractional FTW: load 0x5555_5555 (about inclk0/3). Count c0_en over 3000 cycles; the result is 1000±1, with no two consecutive pulses.
